// File: rtl/percep_ctrl_gen.sv
// Perceptron inference controller: sequences ydx/wght memory preload and per-sample
// net accumulation, compares actual vs desired output and tallies mismatches per run.
module percep_ctrl_gen #(
  parameter int ATTR      = 5,
  parameter int INFER_NUM = 20,
  parameter int PIP_LAT   = 1,
  parameter int RD_LAT    = 1,
  parameter int ERR_THR   = 0,
  parameter int ADDR_YDX  = 7,
  parameter int ADDR_WGHT = 3,
  parameter int CW        = $clog2(INFER_NUM + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode_load,
  input  logic                 sign_out,
  input  logic                 yd,
  output logic                 mem_cs_ydx,
  output logic                 mem_we_ydx,
  output logic                 mem_oe_ydx,
  output logic [ADDR_YDX-1:0]  d_addr_ydx,
  output logic                 mem_cs_wght,
  output logic                 mem_we_wght,
  output logic                 mem_oe_wght,
  output logic [ADDR_WGHT-1:0] d_addr_wght,
  output logic                 rst_add1,
  output logic                 ya_valid,
  output logic                 ya,
  output logic [CW-1:0]        err_cnt,
  output logic                 busy,
  output logic                 infer_done,
  output logic                 infer_fail
);

  // state   | meaning
  // IDLE    | waiting for start after reset
  // STORE   | preload: one ydx/wght word written per cycle
  // CAL_NET | fetch ATTR operands, then drain the adder pipeline
  // CAL_YA  | one cycle: ya valid, mismatch tallied, next sample selected
  // DONE    | run complete; err_cnt and infer_fail held until restart
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STORE   = 3'd1,
    CAL_NET = 3'd2,
    CAL_YA  = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int NW = $clog2(ATTR + PIP_LAT + 1);
  localparam int SW = $clog2(INFER_NUM + 1);

  localparam logic [ADDR_YDX-1:0] STORE_LAST  = ADDR_YDX'(INFER_NUM * ATTR + ATTR - 1);
  localparam logic [ADDR_YDX-1:0] WGHT_BASE   = ADDR_YDX'(INFER_NUM * ATTR);
  localparam logic [ADDR_YDX-1:0] ATTR_Y      = ADDR_YDX'(ATTR);
  localparam logic [NW-1:0]       NET_LAST    = NW'(ATTR + PIP_LAT - 1);
  localparam logic [NW-1:0]       ATTR_N      = NW'(ATTR);
  localparam logic [NW-1:0]       ATTR_M1     = NW'(ATTR - 1);
  localparam logic [NW-1:0]       RD_LAT_N    = NW'(RD_LAT);
  localparam logic [SW-1:0]       LAST_SAMPLE = SW'(INFER_NUM - 1);

  state_t state, state_nxt;

  // addr is the STORE write address, then reused as the running s*ATTR sample base
  logic [ADDR_YDX-1:0] addr;
  logic [NW-1:0]       net_cnt;
  logic [SW-1:0]       sample;
  logic                yd_lat;
  logic [15:0]         fsm_cyc;

  logic          start_go;
  logic          fetch;
  logic [NW-1:0] net_hold;
  logic          mismatch;

  assign start_go = start && ((state == IDLE) || (state == DONE));
  assign fetch    = net_cnt < ATTR_N;
  assign net_hold = fetch ? net_cnt : ATTR_M1;
  assign mismatch = (~sign_out) != yd_lat;

  always_comb begin
    state_nxt   = state;
    mem_cs_ydx  = 1'b0;
    mem_we_ydx  = 1'b0;
    mem_oe_ydx  = 1'b0;
    d_addr_ydx  = '0;
    mem_cs_wght = 1'b0;
    mem_we_wght = 1'b0;
    mem_oe_wght = 1'b0;
    d_addr_wght = '0;
    rst_add1    = 1'b0;
    ya_valid    = 1'b0;
    ya          = 1'b0;
    busy        = 1'b0;
    infer_done  = 1'b0;
    infer_fail  = 1'b0;

    case (state)
      IDLE: begin
        if (start_go) state_nxt = mode_load ? STORE : CAL_NET;
      end

      STORE: begin
        busy        = 1'b1;
        mem_cs_ydx  = 1'b1;
        mem_cs_wght = 1'b1;
        d_addr_ydx  = addr;
        if (addr < WGHT_BASE) begin
          mem_we_ydx = 1'b1;
        end else begin
          mem_we_wght = 1'b1;
          d_addr_wght = ADDR_WGHT'(addr - WGHT_BASE);
        end
        if (addr == STORE_LAST) state_nxt = CAL_NET;
      end

      CAL_NET: begin
        busy        = 1'b1;
        d_addr_ydx  = addr + ADDR_YDX'(net_hold);
        d_addr_wght = ADDR_WGHT'(net_hold);
        rst_add1    = (net_cnt == '0);
        if (fetch) begin
          mem_cs_ydx  = 1'b1;
          mem_oe_ydx  = 1'b1;
          mem_cs_wght = 1'b1;
          mem_oe_wght = 1'b1;
        end
        if (net_cnt == NET_LAST) state_nxt = CAL_YA;
      end

      CAL_YA: begin
        busy        = 1'b1;
        d_addr_ydx  = addr + ADDR_YDX'(ATTR_M1);
        d_addr_wght = ADDR_WGHT'(ATTR_M1);
        ya_valid    = 1'b1;
        ya          = ~sign_out;
        state_nxt   = (sample == LAST_SAMPLE) ? DONE : CAL_NET;
      end

      DONE: begin
        infer_done = 1'b1;
        infer_fail = int'(err_cnt) > ERR_THR;
        if (start_go) state_nxt = mode_load ? STORE : CAL_NET;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr    <= '0;
      net_cnt <= '0;
      sample  <= '0;
      err_cnt <= '0;
      yd_lat  <= 1'b0;
      fsm_cyc <= '0;
    end else begin
      state <= state_nxt;

      if ((state == CAL_NET || state == CAL_YA) && fsm_cyc != 16'hFFFF)
        fsm_cyc <= fsm_cyc + 16'd1;

      case (state)
        IDLE, DONE: begin
          if (start_go) begin
            addr    <= '0;
            net_cnt <= '0;
            sample  <= '0;
            err_cnt <= '0;
          end
        end

        STORE: begin
          net_cnt <= '0;
          addr    <= (addr == STORE_LAST) ? '0 : addr + ADDR_YDX'(1);
        end

        CAL_NET: begin
          net_cnt <= (net_cnt == NET_LAST) ? '0 : net_cnt + NW'(1);
          if (net_cnt == RD_LAT_N) yd_lat <= yd;
        end

        CAL_YA: begin
          net_cnt <= '0;
          sample  <= sample + SW'(1);
          addr    <= addr + ATTR_Y;
          err_cnt <= err_cnt + CW'(mismatch);
        end

        default: ;
      endcase
    end
  end

endmodule
